// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic array.
// Purely declarative: no logic, no latency, no flow control.
package systolic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Four guard bits cover the N=3 sum comfortably; larger arrays grow with log2(N).
    function automatic int acc_width(input int width, input int n);
        int grow;
        grow = $clog2(n) + 2;
        if (grow < 4) grow = 4;
        return 2 * width + grow;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(3 * n);
    endfunction

endpackage

// File: rtl/systolic_array_if.sv
// Operand streams in, control status and the C matrix out of the systolic array.
// Plain wires only: streams are fixed-schedule, there is no ready/valid backpressure.
interface systolic_array_if
    import systolic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N         = 3,
    parameter int ACC_WIDTH = acc_width(WIDTH, N)
);
    logic                        start;
    logic signed [WIDTH-1:0]     row [N];
    logic signed [WIDTH-1:0]     col [N];
    logic                        busy;
    logic                        done;
    logic                        result_valid;
    logic signed [ACC_WIDTH-1:0] result [N][N];

    modport master (
        output start, row, col,
        input  busy, done, result_valid, result
    );

    modport slave (
        input  start, row, col,
        output busy, done, result_valid, result
    );
endinterface

// File: rtl/systolic_pe.sv
// One MAC cell: registers its operands for the right/lower neighbours and accumulates a*b.
// One-cycle operand pass; holds completely while en is low, no backpressure.
module systolic_pe #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2 * WIDTH + 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [WIDTH-1:0]     a_pass,
    output logic signed [WIDTH-1:0]     b_pass,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = a * b;

    // Accumulation wraps on purpose; the signed cast sign-extends the full product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pass <= '0;
            b_pass <= '0;
            acc    <= '0;
        end else if (clr) begin
            a_pass <= '0;
            b_pass <= '0;
            acc    <= '0;
        end else if (en) begin
            a_pass <= a;
            b_pass <= b;
            acc    <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/systolic_array.sv
// N x N output-stationary MAC mesh computing C = A*B from skewed row/column streams.
// done pulses 3N-2 edges after start; start always restarts, there is no backpressure.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N         = 3,
    parameter int ACC_WIDTH = acc_width(WIDTH, N)
) (
    input  logic            clk,
    input  logic            rst_n,
    systolic_array_if.slave bus
);

    localparam int            CW      = cnt_width(N);
    localparam logic [CW-1:0] LAST    = CW'(3 * N - 3);
    localparam logic [0:0]    ST_IDLE = IDLE;
    localparam logic [0:0]    ST_RUN  = RUN;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
    logic          result_valid;

    // start takes priority over completion so a coinciding restart never reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.start) begin
                state        <= ST_RUN;
                cnt          <= '0;
                busy         <= 1'b1;
                result_valid <= 1'b0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.result_valid = result_valid;

    logic signed [WIDTH-1:0]     a_mesh   [N][N];
    logic signed [WIDTH-1:0]     b_mesh   [N][N];
    logic signed [ACC_WIDTH-1:0] acc_mesh [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        // Operands leaving the right and bottom edges have no consumer.
        logic unused_edge;
        assign unused_edge = ^{a_mesh[i][N-1], b_mesh[N-1][i]};

        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [WIDTH-1:0] a_src;
            logic signed [WIDTH-1:0] b_src;

            if (j == 0) begin : g_a_edge
                assign a_src = bus.row[i];
            end else begin : g_a_inner
                assign a_src = a_mesh[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_src = bus.col[j];
            end else begin : g_b_inner
                assign b_src = b_mesh[i-1][j];
            end

            systolic_pe #(
                .WIDTH     (WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (bus.start),
                .en     (busy),
                .a      (a_src),
                .b      (b_src),
                .a_pass (a_mesh[i][j]),
                .b_pass (b_mesh[i][j]),
                .acc    (acc_mesh[i][j])
            );

            assign bus.result[i][j] = acc_mesh[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: table of matrix products plus restart/reset sequences.
module tb_systolic_array;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int AW = 36;

    typedef struct packed {
        logic [0:8][15:0] a;
        logic [0:8][15:0] b;
        logic [0:8][63:0] exp;
    } vec_t;

    typedef int     arr9_t  [9];
    typedef longint larr9_t [9];

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    systolic_array_if #(.WIDTH(W), .N(N), .ACC_WIDTH(AW)) bus   ();
    systolic_array_if #(.WIDTH(W), .N(N), .ACC_WIDTH(32)) bus32 ();

    systolic_array #(.WIDTH(W), .N(N), .ACC_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    systolic_array #(.WIDTH(W), .N(N), .ACC_WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    assign bus32.start = bus.start;
    assign bus32.row   = bus.row;
    assign bus32.col   = bus.col;

    int   cyc            = 0;
    int   done_count     = 0;
    int   last_done_edge = -1;
    int   last_busy_edge = -1;
    int   t_start        = 0;
    int   n_checks       = 0;
    int   n_fail         = 0;
    vec_t vecs [5];

    always @(posedge clk) cyc <= cyc + 1;

    // At a falling edge, cyc is the index of the rising edge just passed.
    always @(negedge clk) begin
        if (bus.done) begin
            done_count     = done_count + 1;
            last_done_edge = cyc;
        end
        if (bus.busy) last_busy_edge = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input arr9_t a, input arr9_t b, input larr9_t e);
        for (int n = 0; n < 9; n++) begin
            vecs[idx].a[n]   = 16'(a[n]);
            vecs[idx].b[n]   = 16'(b[n]);
            vecs[idx].exp[n] = e[n];
        end
    endtask

    task automatic zero_inputs();
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.row[i] = '0;
            bus.col[i] = '0;
        end
    endtask

    // Cycle c drives the values sampled at edge t_start + c.
    task automatic drive(input vec_t v, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) t_start = cyc + 1;
            bus.start = (c == 0);
            for (int i = 0; i < N; i++) begin
                automatic int k = c - 1 - i;
                bus.row[i] = '0;
                bus.col[i] = '0;
                if (k >= 0 && k < N) begin
                    bus.row[i] = v.a[i*N + k];
                    bus.col[i] = v.b[k*N + i];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            zero_inputs();
        end
    endtask

    task automatic check_run(input string tag, input vec_t v, input int base);
        check({tag, " done_count"}, longint'(done_count - base), 1);
        check({tag, " done_edge"}, longint'(last_done_edge), longint'(t_start + 7));
        check({tag, " busy_last_edge"}, longint'(last_busy_edge), longint'(t_start + 6));
        check({tag, " result_valid"}, longint'(bus.result_valid), 1);
        check({tag, " busy_after"}, longint'(bus.busy), 0);
        for (int n = 0; n < 9; n++)
            check($sformatf("%s result[%0d][%0d]", tag, n / N, n % N),
                  longint'(bus.result[n / N][n % N]), longint'(v.exp[n]));
    endtask

    initial begin
        int base;

        set_vec(0, '{1, 2, 3, 4, 5, 6, 7, 8, 9}, '{9, 8, 7, 6, 5, 4, 3, 2, 1},
                '{30, 24, 18, 84, 69, 54, 138, 114, 90});
        set_vec(1, '{1, 0, 0, 0, 1, 0, 0, 0, 1}, '{-32768, 32767, -1, 100, -200, 0, 1, -5, 12345},
                '{-32768, 32767, -1, 100, -200, 0, 1, -5, 12345});
        set_vec(2, '{default: -1}, '{default: 2}, '{default: -6});
        set_vec(3, '{2, 0, 0, 0, 3, 0, 0, 0, -4}, '{1, 2, 3, 4, 5, 6, 7, 8, 9},
                '{2, 4, 6, 12, 15, 18, -28, -32, -36});
        set_vec(4, '{default: -32768}, '{default: -32768}, '{default: 64'd3221225472});

        rst_n = 1'b0;
        zero_inputs();
        repeat (3) @(negedge clk);
        check("reset busy", longint'(bus.busy), 0);
        check("reset done", longint'(bus.done), 0);
        check("reset result_valid", longint'(bus.result_valid), 0);
        for (int n = 0; n < 9; n++)
            check($sformatf("reset result[%0d][%0d]", n / N, n % N),
                  longint'(bus.result[n / N][n % N]), 0);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 5; v++) begin
            base = done_count;
            drive(vecs[v], 6);
            check($sformatf("vec%0d busy_mid", v), longint'(bus.busy), 1);
            check($sformatf("vec%0d result_valid_mid", v), longint'(bus.result_valid), 0);
            idle(4);
            check_run($sformatf("vec%0d", v), vecs[v], base);
        end

        for (int n = 0; n < 9; n++)
            check($sformatf("wrap32 result[%0d][%0d]", n / N, n % N),
                  longint'(bus32.result[n / N][n % N]), -64'sd1073741824);
        idle(5);
        check("hold result_valid", longint'(bus.result_valid), 1);
        check("hold result[2][2]", longint'(bus.result[2][2]), 64'd3221225472);

        // Restart four edges into a run: only the second run completes.
        base = done_count;
        drive(vecs[1], 4);
        drive(vecs[3], 6);
        idle(4);
        check_run("restart", vecs[3], base);

        // Restart on the completing edge: the first run is dropped without done.
        base = done_count;
        drive(vecs[2], 7);
        drive(vecs[0], 6);
        idle(4);
        check_run("restart_on_last", vecs[0], base);

        // Asynchronous reset mid-run clears everything without a clock edge.
        base = done_count;
        drive(vecs[0], 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        zero_inputs();
        #1;
        check("midreset busy", longint'(bus.busy), 0);
        check("midreset result_valid", longint'(bus.result_valid), 0);
        for (int n = 0; n < 9; n++)
            check($sformatf("midreset result[%0d][%0d]", n / N, n % N),
                  longint'(bus.result[n / N][n % N]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("midreset no_done", longint'(done_count - base), 0);
        check("midreset result_valid_after", longint'(bus.result_valid), 0);

        base = done_count;
        drive(vecs[0], 6);
        idle(4);
        check_run("after_reset", vecs[0], base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
